code_lock_seq: RTL
==================

Name: code_lock_seq

Overview:
Parametrised N-button sequence combination lock, successor to the two-button OpenLock.
- Adds configurable button count, code length and code value.
- Adds a failed-attempt counter with timed lockout and a timed auto-relock.
- Sits between debounced, synchronised push-button inputs and the unlock actuator / 7-seg status digit.

Parameters:
NUM_BTN, 2, number of buttons (2..16); SYM_W = max(1, clog2(NUM_BTN))
CODE_LEN, 6, symbols per code (1..15)
CODE_INIT, 6'b110101, packed code of CODE_LEN*SYM_W bits; symbol 0 (entered first) in LSBs; default = b1,b0,b1,b0,b1,b1
MAX_FAIL, 3, consecutive wrong codes before lockout (>=1)
LOCKOUT_CYCLES, 1024, lockout duration in clk cycles (>=1)
OPEN_CYCLES, 256, open duration before auto-relock (>=1)

Ports:
clk  in  1  single clock, rising edge
reset_in  in  1  synchronous, active-high reset
btn_in  in  NUM_BTN  button levels, already debounced and synchronous to clk
out  out  1  1 = lock open
hex_display  out  4  status digit
fail_cnt  out  clog2(MAX_FAIL+1)  consecutive failed attempts
locked_out  out  1  1 = in LOCKOUT

Behaviour:
- Reset is synchronous and active-high, on `clk`/`reset_in`. It sets:
  - state=ENTER, press count=0, mismatch=0, fail_cnt=0, timer=0, out=0, hex_display=0, locked_out=0
  - btn_q<=btn_in, so a button held through reset is not a press.
- Press detection:
  - rise = btn_in & ~btn_q; btn_q<=btn_in every cycle.
  - Exactly one rise bit set = press of that button index.
  - Two or more rise bits in the same cycle = one press flagged wrong.
  - Falling edges are ignored.
- All outputs are registered and reflect the new state in the cycle after the detecting edge.
- ENTER:
  - Each press compares its index against symbol[count].
  - A wrong symbol sets mismatch (sticky); count++.
  - The press with count==CODE_LEN-1 completes the attempt:
    - mismatch clear (including this press) -> OPEN, fail_cnt=0, timer=OPEN_CYCLES-1.
    - otherwise fail_cnt++. If fail_cnt reaches MAX_FAIL -> LOCKOUT, timer=LOCKOUT_CYCLES-1; else stay in ENTER.
  - Count and mismatch clear on every completed attempt.
  - No early abort: a wrong symbol still requires CODE_LEN presses, so no code information leaks.
  - hex_display = count.
- OPEN:
  - out=1, hex_display=4'hA.
  - timer decrements each cycle; on timer==0 -> ENTER (out=0).
  - Any press relocks immediately -> ENTER. The press is consumed and not counted as a symbol.
  - OPEN therefore lasts exactly OPEN_CYCLES cycles with no presses.
- LOCKOUT:
  - locked_out=1, hex_display=4'hE, all presses ignored.
  - Lasts exactly LOCKOUT_CYCLES cycles, then -> ENTER with fail_cnt=0.
- Reset mid-attempt, mid-OPEN or mid-LOCKOUT returns to the reset state next cycle. fail_cnt is cleared by reset.
- Timer width = clog2(max(OPEN_CYCLES, LOCKOUT_CYCLES)+1).

Optional Feature:
CODE_PROG_EN
- Defined:
  - Adds input prog_in (1 bit) and state PROG.
  - In OPEN, prog_in=1 -> PROG (out=0, hex_display=4'hC).
  - In PROG, the next CODE_LEN presses are written as new symbols, LSB-first. Multi-button presses are ignored, not written.
  - The last symbol commits to the code register -> ENTER.
  - Reset aborts PROG without committing and restores the code to CODE_INIT.
- Undefined: no prog_in port; code is constant CODE_INIT.

Test Plan:
Parameters for all scenarios: NUM_BTN=2, CODE_LEN=6, MAX_FAIL=3, LOCKOUT_CYCLES=16, OPEN_CYCLES=32.
- Correct code: reset, then single-cycle presses b1,b0,b1,b0,b1,b1 -> out=1 one cycle after 6th press; hex_display=0..5 during entry, then 4'hA; out=0 after exactly 32 cycles.
- Wrong code: b1,b0,b0,b0,b1,b1 -> out stays 0, fail_cnt=1, hex_display=0.
- Lockout: three wrong attempts -> locked_out=1 and hex_display=4'hE for 16 cycles. The correct code entered during lockout is ignored; afterwards fail_cnt=0 and the correct code opens.
- Held and multi-button input:
  - btn_in held high through reset and release -> no press counted.
  - btn_in=2'b11 rising together counts as a wrong press.
  - Press during OPEN -> out=0 next cycle.
- Reset mid-entry after 3 correct presses -> count=0; the full code is then required to open.
- With CODE_PROG_EN: open, prog_in=1, enter b0×6 -> old code fails, b0×6 opens; reset restores 6'b110101.

Source files
------------

// File: rtl/code_lock_seq.sv
// N-button sequence combination lock with failed-attempt lockout and timed auto-relock.
// Optional CODE_PROG_EN macro adds prog_in and a PROG state that reprograms the code from OPEN.
module code_lock_seq #(
  parameter int NUM_BTN        = 2,
  parameter int CODE_LEN       = 6,
  parameter logic [CODE_LEN*((NUM_BTN > 2) ? $clog2(NUM_BTN) : 1)-1:0] CODE_INIT = 6'b110101,
  parameter int MAX_FAIL       = 3,
  parameter int LOCKOUT_CYCLES = 1024,
  parameter int OPEN_CYCLES    = 256
) (
  input  logic                          clk,
  input  logic                          reset_in,
`ifdef CODE_PROG_EN
  input  logic                          prog_in,
`endif
  input  logic [NUM_BTN-1:0]            btn_in,
  output logic                          out,
  output logic [3:0]                    hex_display,
  output logic [$clog2(MAX_FAIL+1)-1:0] fail_cnt,
  output logic                          locked_out
);

  localparam int SYM_W  = (NUM_BTN > 2) ? $clog2(NUM_BTN) : 1;
  localparam int CODE_W = CODE_LEN * SYM_W;
  localparam int FAIL_W = $clog2(MAX_FAIL + 1);
  localparam int TMR_W  = $clog2(((OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES) + 1);

  typedef enum logic [1:0] {
    ST_ENTER,
    ST_OPEN,
    ST_LOCKOUT,
    ST_PROG
  } state_t;

  state_t              r_state;
  logic [NUM_BTN-1:0]  r_btn_q;
  logic [3:0]          r_count;
  logic                r_mismatch;
  logic [FAIL_W-1:0]   r_fail;
  logic [TMR_W-1:0]    r_timer;
  logic                r_out;
  logic [3:0]          r_hex;
  logic                r_locked;

  logic [NUM_BTN-1:0]  w_rise;
  logic                w_press;
  logic                w_multi;
  logic [SYM_W-1:0]    w_idx;
  logic [SYM_W-1:0]    w_sym;
  logic                w_wrong;
  logic                w_last;
  logic [CODE_W-1:0]   w_code;

`ifdef CODE_PROG_EN
  logic [CODE_W-1:0]   r_code;
  logic [CODE_W-1:0]   r_prog_code;
  logic [CODE_W-1:0]   w_prog_next;

  assign w_code = r_code;

  always_comb begin
    w_prog_next = r_prog_code;
    w_prog_next[r_count*SYM_W +: SYM_W] = w_idx;
  end
`else
  assign w_code = CODE_INIT;
`endif

  assign w_rise  = btn_in & ~r_btn_q;
  assign w_press = |w_rise;
  // Clearing the lowest set bit leaves something only if two or more buttons rose together.
  assign w_multi = (w_rise & (w_rise - NUM_BTN'(1))) != '0;

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    w_idx = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      if (w_rise[i]) w_idx = SYM_W'(i);
    end
  end

  assign w_sym   = w_code[r_count*SYM_W +: SYM_W];
  assign w_wrong = w_multi | (w_idx != w_sym);
  assign w_last  = (r_count == 4'(CODE_LEN - 1));

  // NOTE: state registers use non-blocking assignments so every branch sees pre-edge values.
  always_ff @(posedge clk) begin
    // Edge history tracks btn_in even during reset, so a held button is never a press.
    r_btn_q <= btn_in;
    if (reset_in) begin
      r_state    <= ST_ENTER;
      r_count    <= '0;
      r_mismatch <= 1'b0;
      r_fail     <= '0;
      r_timer    <= '0;
      r_out      <= 1'b0;
      r_hex      <= 4'h0;
      r_locked   <= 1'b0;
`ifdef CODE_PROG_EN
      r_code      <= CODE_INIT;
      r_prog_code <= CODE_INIT;
`endif
    end else begin
      case (r_state)
        ST_ENTER: begin
          if (w_press) begin
            if (w_last) begin
              r_count    <= '0;
              r_mismatch <= 1'b0;
              if (!(r_mismatch || w_wrong)) begin
                r_state <= ST_OPEN;
                r_fail  <= '0;
                r_timer <= TMR_W'(OPEN_CYCLES - 1);
                r_out   <= 1'b1;
                r_hex   <= 4'hA;
              end else if (r_fail + 1'b1 == FAIL_W'(MAX_FAIL)) begin
                r_state  <= ST_LOCKOUT;
                r_fail   <= r_fail + 1'b1;
                r_timer  <= TMR_W'(LOCKOUT_CYCLES - 1);
                r_locked <= 1'b1;
                r_hex    <= 4'hE;
              end else begin
                r_fail <= r_fail + 1'b1;
                r_hex  <= 4'h0;
              end
            end else begin
              r_count    <= r_count + 1'b1;
              r_mismatch <= r_mismatch | w_wrong;
              r_hex      <= r_count + 1'b1;
            end
          end
        end

        ST_OPEN: begin
          if (w_press || r_timer == '0) begin
            r_state <= ST_ENTER;
            r_out   <= 1'b0;
            r_hex   <= 4'h0;
          end
`ifdef CODE_PROG_EN
          else if (prog_in) begin
            r_state <= ST_PROG;
            r_count <= '0;
            r_out   <= 1'b0;
            r_hex   <= 4'hC;
          end
`endif
          else begin
            r_timer <= r_timer - 1'b1;
          end
        end

        ST_LOCKOUT: begin
          if (r_timer == '0) begin
            r_state  <= ST_ENTER;
            r_fail   <= '0;
            r_locked <= 1'b0;
            r_hex    <= 4'h0;
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        end

`ifdef CODE_PROG_EN
        ST_PROG: begin
          if (w_press && !w_multi) begin
            r_prog_code <= w_prog_next;
            if (w_last) begin
              r_code  <= w_prog_next;
              r_state <= ST_ENTER;
              r_count <= '0;
              r_hex   <= 4'h0;
            end else begin
              r_count <= r_count + 1'b1;
            end
          end
        end
`endif

        default: begin
          r_state <= ST_ENTER;
          r_count <= '0;
          r_out   <= 1'b0;
          r_hex   <= 4'h0;
        end
      endcase
    end
  end

  assign out         = r_out;
  assign hex_display = r_hex;
  assign fail_cnt    = r_fail;
  assign locked_out  = r_locked;

endmodule
